alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_pkg.sv | 16 +
 rtl/alarm_ctrl_time_add.sv | 30 +++
 rtl/alarm_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared encodings and time constants
// for the alarm clock controller.
package alarm_pkg;

    localparam int TW      = 8;
    localparam int HR_MAX  = 24;
    localparam int MIN_MAX = 60;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        SET_TIME  = 2'b01,
        SET_ALARM = 2'b10,
        RING      = 2'b11
    } state_t;

endpackage

// File: rtl/alarm_ctrl_time_add.sv
// time_add: (hr,min) + delta minutes, mod-60 minutes
// with optional carry into a mod-24 hour.
import alarm_pkg::*;

module time_add (
    input  logic [TW-1:0] hr,
    input  logic [TW-1:0] mins,
    input  logic [TW-1:0] delta,
    input  logic          carry,
    output logic [TW-1:0] sum_hr,
    output logic [TW-1:0] sum_min
);

    localparam logic [TW:0]   MMAX = (TW+1)'(MIN_MAX);
    localparam logic [TW-1:0] HMAX = TW'(HR_MAX);

    logic [TW:0]   m_sum;
    logic          wrap;
    logic [TW-1:0] h_sum;

    // delta never exceeds 60, so one subtraction suffices
    always_comb begin
        m_sum   = {1'b0, mins} + {1'b0, delta};
        wrap    = (m_sum >= MMAX);
        sum_min = wrap ? TW'(m_sum - MMAX) : m_sum[TW-1:0];
        h_sum   = hr + {{(TW-1){1'b0}}, wrap & carry};
        sum_hr  = (h_sum >= HMAX) ? h_sum - HMAX : h_sum;
    end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm clock mode FSM with time/alarm
// editing, ring, snooze and ring timeout.
import alarm_pkg::*;

module alarm_ctrl #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_mode,
    input  logic          btn_inc_hr,
    input  logic          btn_inc_min,
    input  logic          btn_arm,
    input  logic          btn_snooze,
    input  logic          btn_stop,
    input  logic [TW-1:0] cur_hr,
    input  logic [TW-1:0] cur_min,
    input  logic [TW-1:0] cur_sec,
    output logic          count_en,
    output logic          load_en,
    output logic [TW-1:0] load_hr,
    output logic [TW-1:0] load_min,
    output logic [TW-1:0] alarm_hr,
    output logic [TW-1:0] alarm_min,
    output logic          armed,
    output logic          buzzer,
    output logic [1:0]    mode
);

    localparam logic [TW-1:0] HR_STEP = TW'(MIN_MAX);
    localparam logic [TW-1:0] SNZ     = TW'(SNOOZE_MIN);
    localparam logic [TW-1:0] RC_LAST = TW'(RING_TIMEOUT_S - 1);

    state_t        state, state_n;
    logic [TW-1:0] edit_hr, edit_min;
    logic [TW-1:0] tgt_hr, tgt_min;
    logic [TW-1:0] sec_q, ring_cnt;
    logic [TW-1:0] src_hr, src_min;
    logic [TW-1:0] d_hr, d_min;
    logic [TW-1:0] h_hr, h_min;
    logic [TW-1:0] e_hr, e_min;
    logic [TW-1:0] s_hr, s_min;
    logic          sec_chg, trig, ring_end, stop;

    assign mode = state;

    assign src_hr  = (state == SET_ALARM) ? alarm_hr  : edit_hr;
    assign src_min = (state == SET_ALARM) ? alarm_min : edit_min;
    assign d_hr    = btn_inc_hr ? HR_STEP : '0;
    assign d_min   = {{(TW-1){1'b0}}, btn_inc_min};

    // hour step: +60 min always carries, minutes unchanged
    time_add u_hr (
        .hr(src_hr), .mins(src_min), .delta(d_hr),
        .carry(1'b1), .sum_hr(h_hr), .sum_min(h_min)
    );

    // minute step: wraps without touching the hour
    time_add u_min (
        .hr(h_hr), .mins(h_min), .delta(d_min),
        .carry(1'b0), .sum_hr(e_hr), .sum_min(e_min)
    );

    time_add u_snz (
        .hr(tgt_hr), .mins(tgt_min), .delta(SNZ),
        .carry(1'b1), .sum_hr(s_hr), .sum_min(s_min)
    );

    assign sec_chg  = (cur_sec != sec_q);
    assign trig     = armed && (cur_hr == tgt_hr) &&
                      (cur_min == tgt_min) &&
                      (cur_sec == '0) && (sec_q != '0);
    assign ring_end = sec_chg && (ring_cnt == RC_LAST);
    assign stop     = btn_stop || ring_end;

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            RUN: begin
                if (trig)
                    state_n = RING;
                else if (btn_mode)
                    state_n = SET_TIME;
            end
            SET_TIME: begin
                if (btn_mode)
                    state_n = SET_ALARM;
            end
            SET_ALARM: begin
                if (btn_mode)
                    state_n = RUN;
            end
            RING: begin
                if (stop || btn_snooze)
                    state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    // state register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            count_en <= 1'b1;
            buzzer   <= 1'b0;
            load_en  <= 1'b0;
            load_hr  <= '0;
            load_min <= '0;
            sec_q    <= '0;
            ring_cnt <= '0;
        end else begin
            state    <= state_n;
            count_en <= (state_n != SET_TIME);
            buzzer   <= (state_n == RING);
            load_en  <= (state == SET_TIME) && btn_mode;
            sec_q    <= cur_sec;
            if (state == SET_TIME && btn_mode) begin
                load_hr  <= edit_hr;
                load_min <= edit_min;
            end
            if (state == RING && state_n == RING)
                ring_cnt <= ring_cnt + TW'(sec_chg);
            else
                ring_cnt <= '0;
        end
    end

    // edit, alarm, target and arm registers
    always_ff @(posedge clk) begin
        if (reset) begin
            edit_hr   <= '0;
            edit_min  <= '0;
            alarm_hr  <= '0;
            alarm_min <= '0;
            tgt_hr    <= '0;
            tgt_min   <= '0;
            armed     <= 1'b0;
        end else begin
            if (btn_arm && state != RING)
                armed <= ~armed;
            unique case (state)
                RUN: begin
                    if (state_n == SET_TIME) begin
                        edit_hr  <= cur_hr;
                        edit_min <= cur_min;
                    end
                    if (btn_arm && armed) begin
                        tgt_hr  <= alarm_hr;
                        tgt_min <= alarm_min;
                    end
                end
                SET_TIME: begin
                    if (!btn_mode) begin
                        edit_hr  <= e_hr;
                        edit_min <= e_min;
                    end
                end
                SET_ALARM: begin
                    if (!btn_mode) begin
                        alarm_hr  <= e_hr;
                        alarm_min <= e_min;
                    end else begin
                        tgt_hr  <= alarm_hr;
                        tgt_min <= alarm_min;
                    end
                end
                RING: begin
                    if (stop) begin
                        tgt_hr  <= alarm_hr;
                        tgt_min <= alarm_min;
                    end else if (btn_snooze) begin
                        tgt_hr  <= s_hr;
                        tgt_min <= s_min;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scoreboard bench for
// alarm_ctrl with default parameters.
module tb_alarm_ctrl;

    typedef struct packed {
        logic [1:0] mode;
        logic       buzzer;
        logic       count_en;
        logic       load_en;
        logic       armed;
        logic [7:0] lhr;
        logic [7:0] lmin;
        logic [7:0] ahr;
        logic [7:0] amin;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc_hr, btn_inc_min;
    logic       btn_arm, btn_snooze, btn_stop;
    logic [7:0] cur_hr, cur_min, cur_sec;
    logic       count_en, load_en, armed, buzzer;
    logic [7:0] load_hr, load_min, alarm_hr, alarm_min;
    logic [1:0] mode;

    obs_t  e;
    obs_t  expq[$];
    string tagq[$];
    int    vectors = 0;
    int    miscompares = 0;

    alarm_ctrl dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc_hr(btn_inc_hr),
        .btn_inc_min(btn_inc_min), .btn_arm(btn_arm),
        .btn_snooze(btn_snooze), .btn_stop(btn_stop),
        .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
        .count_en(count_en), .load_en(load_en),
        .load_hr(load_hr), .load_min(load_min),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .armed(armed), .buzzer(buzzer), .mode(mode)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        btn_mode = 0; btn_inc_hr = 0; btn_inc_min = 0;
        btn_arm = 0; btn_snooze = 0; btn_stop = 0;
    endtask

    task automatic cur(input int h, input int m, input int s);
        cur_hr = 8'(h); cur_min = 8'(m); cur_sec = 8'(s);
    endtask

    task automatic chk();
        obs_t  x, o;
        string t;
        x = expq.pop_front();
        t = tagq.pop_front();
        o = '{mode, buzzer, count_en, load_en, armed,
              load_hr, load_min, alarm_hr, alarm_min};
        vectors++;
        assert (o === x) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, o, x);
        end
    endtask

    task automatic step(input string tag);
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        clr();
        chk();
    endtask

    initial begin
        clr();
        reset = 1;
        cur(22, 10, 5);
        e = '0;
        e.count_en = 1;
        step("reset");
        reset = 0;

        btn_mode = 1; e.mode = 2'b01; e.count_en = 0;
        step("enter_set_time");
        for (int i = 0; i < 3; i++) begin
            btn_inc_hr = 1;
            step("edit_inc_hr");
        end
        btn_mode = 1; e.mode = 2'b10; e.count_en = 1;
        e.load_en = 1; e.lhr = 1; e.lmin = 10;
        step("load_strobe");
        e.load_en = 0;
        step("load_one_cycle");

        for (int i = 0; i < 30; i++) begin
            btn_inc_min = 1;
            btn_inc_hr = (i < 7);
            e.amin = 8'(i + 1);
            if (i < 7) e.ahr = 8'(i + 1);
            step("alarm_edit");
        end
        btn_arm = 1; e.armed = 1;
        step("arm");
        btn_mode = 1; e.mode = 2'b00;
        step("to_run");

        cur(7, 29, 59); step("pre_fire");
        cur(7, 30, 0); e.mode = 2'b11; e.buzzer = 1;
        step("fire");
        btn_mode = 1; btn_inc_hr = 1; btn_arm = 1;
        step("ring_ignores");
        btn_stop = 1; e.mode = 2'b00; e.buzzer = 0;
        step("stop");
        step("no_refire");
        step("no_refire2");
        btn_arm = 1; e.armed = 0;
        step("disarm");
        cur(7, 29, 59); step("unarmed_pre");
        cur(7, 30, 0); step("unarmed_no_ring");
        btn_arm = 1; e.armed = 1;
        step("rearm");

        btn_mode = 1; e.mode = 2'b01; e.count_en = 0;
        step("set_time2");
        btn_mode = 1; e.mode = 2'b10; e.count_en = 1;
        e.load_en = 1; e.lhr = 7; e.lmin = 30;
        step("load2");
        e.load_en = 0;
        for (int i = 0; i < 28; i++) begin
            btn_inc_min = 1;
            btn_inc_hr = (i < 16);
            e.amin = 8'(30 + i + 1);
            if (i < 16) e.ahr = 8'(7 + i + 1);
            step("alarm_edit2");
        end
        btn_inc_min = 1; e.amin = 59;
        step("min_59");
        btn_inc_min = 1; e.amin = 0;
        step("min_wrap_no_carry");
        for (int i = 0; i < 58; i++) begin
            btn_inc_min = 1;
            e.amin = 8'(i + 1);
            step("alarm_edit3");
        end
        btn_mode = 1; e.mode = 2'b00;
        step("to_run2");

        cur(23, 57, 59); step("pre_fire2");
        cur(23, 58, 0); e.mode = 2'b11; e.buzzer = 1;
        step("fire_2358");
        btn_snooze = 1; e.mode = 2'b00; e.buzzer = 0;
        step("snooze1");
        cur(23, 57, 59); step("pre_old");
        cur(23, 58, 0); step("old_target_silent");
        cur(0, 2, 59); step("pre_snz");
        cur(0, 3, 0); e.mode = 2'b11; e.buzzer = 1;
        step("snooze_fire_0003");
        btn_snooze = 1; e.mode = 2'b00; e.buzzer = 0;
        step("snooze2");
        cur(0, 7, 59); step("pre_snz2");
        cur(0, 8, 0); e.mode = 2'b11; e.buzzer = 1;
        step("snooze_fire_0008");
        btn_stop = 1; btn_snooze = 1;
        e.mode = 2'b00; e.buzzer = 0;
        step("stop_wins");
        cur(0, 12, 59); step("pre_0013");
        cur(0, 13, 0); step("no_snooze_0013");
        cur(23, 57, 59); step("pre_tgt");
        cur(23, 58, 0); e.mode = 2'b11; e.buzzer = 1;
        step("target_restored");

        for (int k = 1; k <= 60; k++) begin
            cur(23, (k == 60) ? 59 : 58, k % 60);
            if (k == 60) begin
                e.mode = 2'b00;
                e.buzzer = 0;
            end
            step("ring_timeout");
        end
        cur(23, 57, 59); step("pre_after_to");
        cur(23, 58, 0); e.mode = 2'b11; e.buzzer = 1;
        step("ring_after_timeout");

        reset = 1; btn_snooze = 1;
        e = '0; e.count_en = 1;
        step("reset_in_ring");
        reset = 0;
        btn_mode = 1; e.mode = 2'b01; e.count_en = 0;
        step("set_time3");
        btn_inc_hr = 1;
        step("edit3");
        reset = 1; btn_mode = 1;
        e = '0; e.count_en = 1;
        step("reset_in_set_time");
        reset = 0;
        step("no_load_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
